// File: rtl/crossbar_pkg.sv
// Shared types, defaults and the allocation-window helper for the crossbar reorder buffer.
package crossbar_pkg;

    localparam int CROSSBAR_ROB_DEPTH_DEFAULT = 16;

    typedef struct packed {
        logic dup;
        logic unalloc;
    } rob_err_t;

    // True when tag lies in [rd_ptr, wr_ptr); pointers carry a wrap bit above tag_width.
    function automatic logic rob_tag_in_window(
        input logic [31:0] rd_ptr,
        input logic [31:0] wr_ptr,
        input logic [31:0] tag,
        input int          tag_width
    );
        logic [31:0] ptr_mask;
        logic [31:0] tag_mask;
        logic [31:0] used;
        logic [31:0] off;
        ptr_mask = (32'd1 << (tag_width + 1)) - 32'd1;
        tag_mask = (32'd1 << tag_width) - 32'd1;
        used     = (wr_ptr - rd_ptr) & ptr_mask;
        off      = (tag - rd_ptr) & tag_mask;
        return off < used;
    endfunction

endpackage

// File: rtl/crossbar_rob_out_reg.sv
// Single-entry AXI-Stream output register: load when empty or being accepted, hold otherwise.
module crossbar_rob_out_reg #(
    parameter int TDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [TDATA_WIDTH-1:0] load_data,
    output logic                   avail,
    output logic                   tvalid,
    output logic [TDATA_WIDTH-1:0] tdata,
    input  logic                   tready
);

    assign avail = !tvalid || tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tvalid <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/crossbar_rob_gen.sv
// Reorder buffer for crossbar responses: sequential tags out, out-of-order responses in, in-order data out.
// Optional illegal-response checking and the err_tag port are enabled by CROSSBAR_ROB_ERR_CHECK_EN.
module crossbar_rob_gen
    import crossbar_pkg::*;
#(
    parameter  int S_QTY       = 4,
    parameter  int TDATA_WIDTH = 32,
    parameter  int DEPTH       = CROSSBAR_ROB_DEPTH_DEFAULT,
    localparam int TAG_WIDTH   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         resetn,
    output logic                         m_axis_tag_tvalid,
    input  logic                         m_axis_tag_tready,
    output logic [TAG_WIDTH-1:0]         m_axis_tag_tdata,
    input  logic [S_QTY-1:0]             s_axis_data_tvalid,
    input  logic [S_QTY*TDATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic [S_QTY*TAG_WIDTH-1:0]   s_axis_data_tuser,
    output logic                         m_axis_data_tvalid,
    input  logic                         m_axis_data_tready,
    output logic [TDATA_WIDTH-1:0]       m_axis_data_tdata,
    output logic [TAG_WIDTH:0]           occupancy
`ifdef CROSSBAR_ROB_ERR_CHECK_EN
    ,
    output logic [1:0]                   err_tag
`endif
);

    logic [TAG_WIDTH:0]       wr_ptr;
    logic [TAG_WIDTH:0]       rd_ptr;
    logic [TAG_WIDTH:0]       occ_q;
    logic [DEPTH-1:0]         slot_valid;
    logic [TDATA_WIDTH-1:0]   slot_data [DEPTH];

    logic [TAG_WIDTH-1:0]     wr_idx;
    logic [TAG_WIDTH-1:0]     rd_idx;
    logic                     alloc;
    logic                     pop;
    logic                     head_valid;
    logic                     out_avail;

    logic [TAG_WIDTH-1:0]     ch_tag  [S_QTY];
    logic [TDATA_WIDTH-1:0]   ch_data [S_QTY];
    logic [S_QTY-1:0]         ch_accept;

    logic [DEPTH-1:0]         wr_en;
    logic [TDATA_WIDTH-1:0]   wr_data [DEPTH];
    logic [DEPTH-1:0]         alloc_clr;
    logic [DEPTH-1:0]         pop_clr;

    for (genvar c = 0; c < S_QTY; c++) begin : g_ch
        assign ch_tag[c]  = s_axis_data_tuser[c*TAG_WIDTH +: TAG_WIDTH];
        assign ch_data[c] = s_axis_data_tdata[c*TDATA_WIDTH +: TDATA_WIDTH];
    end

    assign wr_idx            = wr_ptr[TAG_WIDTH-1:0];
    assign rd_idx            = rd_ptr[TAG_WIDTH-1:0];
    assign occupancy         = occ_q;
    assign m_axis_tag_tvalid = (occ_q != (TAG_WIDTH+1)'(DEPTH));
    assign m_axis_tag_tdata  = wr_idx;
    assign alloc             = m_axis_tag_tvalid && m_axis_tag_tready;
    assign head_valid        = slot_valid[rd_idx];
    assign pop               = (occ_q != '0) && head_valid && out_avail;

`ifdef CROSSBAR_ROB_ERR_CHECK_EN
    logic [S_QTY-1:0] in_win;
    logic [S_QTY-1:0] dup_hit;
    rob_err_t         err_q;

    always_comb begin
        in_win    = '0;
        dup_hit   = '0;
        ch_accept = '0;
        for (int c = 0; c < S_QTY; c++) begin
            in_win[c]    = rob_tag_in_window(32'(rd_ptr), 32'(wr_ptr), 32'(ch_tag[c]), TAG_WIDTH);
            dup_hit[c]   = slot_valid[ch_tag[c]];
            ch_accept[c] = s_axis_data_tvalid[c] && in_win[c] && !dup_hit[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= '0;
        end else begin
            err_q.unalloc <= err_q.unalloc | (|(s_axis_data_tvalid & ~in_win));
            err_q.dup     <= err_q.dup | (|(s_axis_data_tvalid & in_win & dup_hit));
        end
    end

    assign err_tag = {err_q.dup, err_q.unalloc};
`else
    assign ch_accept = s_axis_data_tvalid;
`endif

    // Ascending channel scan: the highest channel hitting a slot overrides lower ones.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data[i] = '0;
        end
        for (int c = 0; c < S_QTY; c++) begin
            if (ch_accept[c]) begin
                wr_en[ch_tag[c]]   = 1'b1;
                wr_data[ch_tag[c]] = ch_data[c];
            end
        end
    end

    assign alloc_clr = alloc ? (DEPTH'(1) << wr_idx) : '0;
    assign pop_clr   = pop ? (DEPTH'(1) << rd_idx) : '0;

    // Allocation clearing a slot overrides a response landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            slot_valid <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ_q      <= '0;
        end else begin
            slot_valid <= (slot_valid | wr_en) & ~alloc_clr & ~pop_clr;
            if (alloc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({alloc, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                slot_data[i] <= wr_data[i];
            end
        end
    end

    crossbar_rob_out_reg #(
        .TDATA_WIDTH(TDATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .resetn    (resetn),
        .load      (pop),
        .load_data (slot_data[rd_idx]),
        .avail     (out_avail),
        .tvalid    (m_axis_data_tvalid),
        .tdata     (m_axis_data_tdata),
        .tready    (m_axis_data_tready)
    );

endmodule

// File: tb/tb_crossbar_rob_gen.sv
// Scoreboard bench for crossbar_rob_gen: tag-order reference queue, random response order and backpressure.
module tb_crossbar_rob_gen;
  import crossbar_pkg::*;

  localparam int S_QTY = 4;
  localparam int TW    = 32;
  localparam int DEPTH = 16;
  localparam int TAGW  = 4;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  tag_tvalid;
  logic                  tag_tready;
  logic [TAGW-1:0]       tag_tdata;
  logic [S_QTY-1:0]      s_tvalid;
  logic [S_QTY*TW-1:0]   s_tdata;
  logic [S_QTY*TAGW-1:0] s_tuser;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [TW-1:0]         m_tdata;
  logic [TAGW:0]         occupancy;
`ifdef CROSSBAR_ROB_ERR_CHECK_EN
  logic [1:0]            err_tag;
`endif

  crossbar_rob_gen #(
    .S_QTY(S_QTY),
    .TDATA_WIDTH(TW),
    .DEPTH(DEPTH)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .m_axis_tag_tvalid  (tag_tvalid),
    .m_axis_tag_tready  (tag_tready),
    .m_axis_tag_tdata   (tag_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tuser  (s_tuser),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tdata  (m_tdata),
    .occupancy          (occupancy)
`ifdef CROSSBAR_ROB_ERR_CHECK_EN
    ,
    .err_tag            (err_tag)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] exp_q[$];
  int unsigned   beat_cyc_q[$];
  int            n_beats = 0;
  bit            rand_ready = 1'b0;
  int            next_tag = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // downstream ready: always 1 or 50% random
  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: pops the expected queue on every output handshake and checks hold stability
  logic          held = 1'b0;
  logic [TW-1:0] held_data;
  always @(negedge clk) begin
    if (!resetn) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(m_tvalid), 64'd1);
        check("hold_data", 64'(m_tdata), 64'(held_data));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else check("beat_data", 64'(m_tdata), 64'(exp_q.pop_front()));
        n_beats++;
        beat_cyc_q.push_back(cyc);
      end
      held      = m_tvalid && !m_tready;
      held_data = m_tdata;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_tag(output logic [TAGW-1:0] t);
    bit got = 1'b0;
    t = '0;
    tag_tready = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (tag_tvalid) begin
        t   = tag_tdata;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    tag_tready = 1'b0;
    if (!got) begin
      fail_now("tag_alloc_timeout");
    end else begin
      check("tag_value", 64'(t), 64'(next_tag % DEPTH));
      next_tag++;
    end
  endtask

  task automatic set_ch(input int ch, input logic [TAGW-1:0] tag, input logic [TW-1:0] data);
    s_tvalid[ch]            = 1'b1;
    s_tuser[ch*TAGW +: TAGW] = tag;
    s_tdata[ch*TW +: TW]     = data;
  endtask

  task automatic resp(input int ch, input logic [TAGW-1:0] tag, input logic [TW-1:0] data);
    set_ch(ch, tag, data);
    tick();
    s_tvalid = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  logic [TAGW-1:0] tags[$];
  logic [TAGW-1:0] pend_q[$];
  logic [TW-1:0]   data_of[DEPTH];
  logic [TAGW-1:0] t;
  logic [TW-1:0]   d;
  int unsigned     r0;
  int              base;

  initial begin
    resetn     = 1'b0;
    tag_tready = 1'b0;
    s_tvalid   = '0;
    s_tdata    = '0;
    s_tuser    = '0;
    m_tready   = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    @(negedge clk);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_valid", 64'(m_tvalid), 64'd0);
    check("rst_tag_valid", 64'(tag_tvalid), 64'd1);
    check("rst_tag_data", 64'(tag_tdata), 64'd0);
`ifdef CROSSBAR_ROB_ERR_CHECK_EN
    check("rst_err_tag", 64'(err_tag), 64'd0);
`endif
    tick();

    // in-order fill to full, then in-order responses on ch0
    tags.delete();
    for (int i = 0; i < DEPTH; i++) begin
      alloc_tag(t);
      tags.push_back(t);
      exp_q.push_back(32'h100 + 32'(i));
    end
    @(negedge clk);
    check("full_occupancy", 64'(occupancy), 64'(DEPTH));
    check("full_tag_valid", 64'(tag_tvalid), 64'd0);
    tick();
    tag_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_no_tag", 64'(tag_tvalid), 64'd0);
      tick();
    end
    tag_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) resp(0, tags[i], 32'h100 + 32'(i));
    wait_drain();
    @(negedge clk);
    check("drained_occupancy", 64'(occupancy), 64'd0);
    check("drained_tag_valid", 64'(tag_tvalid), 64'd1);
    tick();

    // reverse-order responses: beats start 2 cycles after the head's response
    tags.delete();
    for (int i = 0; i < 4; i++) begin
      alloc_tag(t);
      tags.push_back(t);
      exp_q.push_back(32'h200 + 32'(t));
    end
    beat_cyc_q.delete();
    base = n_beats;
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) r0 = cyc;
      resp(i, tags[i], 32'h200 + 32'(tags[i]));
    end
    wait_drain();
    check("rev_beat_count", 64'(n_beats - base), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < beat_cyc_q.size()) check("rev_beat_cycle", 64'(beat_cyc_q[k]), 64'(r0 + 2 + k));
      else fail_now("rev_beat_missing");
    end

    // random response order, random channel, 50% backpressure, 40 tags across pointer wrap
    rand_ready = 1'b1;
    pend_q.delete();
    begin
      int n_alloc = 0;
      for (int it = 0; it < 3000 && (n_alloc < 40 || pend_q.size() != 0); it++) begin
        if (n_alloc < 40 && exp_q.size() < DEPTH && ($urandom_range(0, 1) == 1 || pend_q.size() == 0)) begin
          alloc_tag(t);
          d = $urandom;
          data_of[t] = d;
          exp_q.push_back(d);
          pend_q.push_back(t);
          n_alloc++;
        end else if (pend_q.size() != 0) begin
          int idx;
          idx = $urandom_range(0, pend_q.size() - 1);
          t = pend_q[idx];
          pend_q.delete(idx);
          resp($urandom_range(0, S_QTY - 1), t, data_of[t]);
        end else begin
          tick();
        end
      end
      check("rand_alloc_count", 64'(n_alloc), 64'd40);
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) tick();

    // reset with 6 outstanding, 2 of them answered (not the head)
    tags.delete();
    for (int i = 0; i < 6; i++) begin
      alloc_tag(t);
      tags.push_back(t);
      exp_q.push_back(32'h500 + 32'(i));
    end
    resp(1, tags[1], 32'h501);
    resp(2, tags[2], 32'h502);
    resetn = 1'b0;
    exp_q.delete();
    tick();
    resetn   = 1'b1;
    next_tag = 0;
    @(negedge clk);
    check("mid_rst_occupancy", 64'(occupancy), 64'd0);
    check("mid_rst_out_valid", 64'(m_tvalid), 64'd0);
    check("mid_rst_tag_data", 64'(tag_tdata), 64'd0);
    tick();
    repeat (4) tick();
    check("mid_rst_no_beat", 64'(exp_q.size()), 64'd0);
    alloc_tag(t);
    exp_q.push_back(32'h5A5A);
    resp(3, t, 32'h5A5A);
    wait_drain();

    // collision: ch1 and ch2 hit tag 5 together, the higher channel's data wins
    tags.delete();
    for (int i = 1; i <= 5; i++) begin
      alloc_tag(t);
      tags.push_back(t);
      exp_q.push_back((i == 5) ? 32'hBB : 32'h300 + 32'(i));
    end
    for (int i = 0; i < 4; i++) resp(0, tags[i], 32'h300 + 32'(i + 1));
    set_ch(1, tags[4], 32'hAA);
    set_ch(2, tags[4], 32'hBB);
    tick();
    s_tvalid = '0;
    wait_drain();

`ifdef CROSSBAR_ROB_ERR_CHECK_EN
    // unallocated tag 9 is dropped and flagged
    base = n_beats;
    resp(0, 4'd9, 32'hDEAD);
    repeat (4) tick();
    @(negedge clk);
    check("err_unalloc", 64'(err_tag), 64'b01);
    check("err_unalloc_no_beat", 64'(n_beats - base), 64'd0);
    check("err_unalloc_occupancy", 64'(occupancy), 64'd0);
    tick();
    // duplicate on a waiting (non-head) slot keeps the original data
    tags.delete();
    for (int i = 0; i < 2; i++) begin
      alloc_tag(t);
      tags.push_back(t);
      exp_q.push_back(32'h600 + 32'(i));
    end
    resp(1, tags[1], 32'h601);
    resp(2, tags[1], 32'h777);
    @(negedge clk);
    check("err_dup", 64'(err_tag), 64'b11);
    tick();
    resp(0, tags[0], 32'h600);
    wait_drain();
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
